// File: rtl/dct_axis_bridge_if.sv
// dct_axis_bridge_if: AXI-Stream bundle shared by the pixel input and the coded
// output of dct_axis_bridge. The slave side has no tkeep because the pixel input
// stream carries none; the master side drives tkeep as all ones.
interface dct_axis_bridge_if #(
    parameter int DATA_W = 16
) ();
    localparam int KEEP_W = DATA_W / 8;

    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        input  tready,
        output tlast
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready,
        input  tlast
    );
endinterface

// File: rtl/dct_axis_bridge.sv
// dct_axis_bridge: AXI-Stream wrapper around an external block DCT/quantise/RLE core.
// Input beats are forwarded to the core one cycle after acceptance. A new block is
// only admitted when the output FIFO has room for a whole block on top of every
// block still in flight, so the core never overruns the FIFO. Coded words from
// the core are buffered in a first-word-fall-through FIFO tagged with an eof bit,
// and a small tag FIFO carries the per-block frame flag that becomes m_axis tlast.
// Optional build macro DCT_AXIS_BRIDGE_STATS_EN adds blocks_out, frames_out and
// the sticky err_drop flag.
// FIFO_DEPTH and TAG_DEPTH are powers of two and at least 2.
module dct_axis_bridge #(
    parameter int LANES        = 2,
    parameter int IN_WIDTH     = 8,
    parameter int OUT_WIDTH    = 16,
    parameter int BLOCK_PIXELS = 64,
    parameter int FIFO_DEPTH   = 64,
    parameter int TAG_DEPTH    = 8
) (
    input  logic                         aclk,
    input  logic                         areset,
    dct_axis_bridge_if.slave             s_axis,
    dct_axis_bridge_if.master            m_axis,
    output logic                         core_rst,
    output logic [LANES*IN_WIDTH-1:0]    core_wdata,
    output logic                         core_wen,
    input  logic [LANES*OUT_WIDTH-1:0]   core_rdata,
    input  logic                         core_rsync
`ifdef DCT_AXIS_BRIDGE_STATS_EN
    ,
    output logic [31:0]                  blocks_out,
    output logic [31:0]                  frames_out,
    output logic                         err_drop
`endif
);

    localparam int IW    = LANES * IN_WIDTH;
    localparam int OW    = LANES * OUT_WIDTH;
    localparam int BEATS = BLOCK_PIXELS / LANES;
    localparam int PIX_W = (BLOCK_PIXELS > 1) ? $clog2(BLOCK_PIXELS) : 1;
    localparam int FA    = $clog2(FIFO_DEPTH);
    localparam int TA    = $clog2(TAG_DEPTH);
    localparam int INF_W = TA + 1;

    localparam logic [PIX_W-1:0] PIX_STEP  = PIX_W'(LANES);
    localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(BLOCK_PIXELS - LANES);
    localparam logic [FA:0]      FIFO_FULL = (FA + 1)'(FIFO_DEPTH);
    localparam logic [FA:0]      PTR_ONE   = (FA + 1)'(1);
    localparam logic [TA:0]      TAG_FULL  = (TA + 1)'(TAG_DEPTH);
    localparam logic [TA:0]      TAG_ONE   = (TA + 1)'(1);
    localparam logic [INF_W-1:0] INF_ONE   = INF_W'(1);

    // Input side state
    logic [PIX_W-1:0] pixCnt_q, pixCnt_d;
    logic [INF_W-1:0] inflight_q, inflight_d;
    logic             fflag_q, fflag_d;
    logic             rdyEn_q;
    logic             coreWen_q;
    logic [IW-1:0]    coreWdata_q;

    // Output FIFO state
    logic [FA:0]      wrPtr_q, rdPtr_q;
    logic [OW:0]      fifoMem [FIFO_DEPTH];

    // Frame tag FIFO state
    logic [TA:0]          tagWr_q, tagRd_q;
    logic [TAG_DEPTH-1:0] tagMem_q;

    // Combinational helpers
    logic          acc, blockStart, lastBeat, rsvOk;
    logic          coreEof, coreEofWr;
    logic [FA:0]   fifoCount;
    logic          fifoEmpty, fifoFull, fifoPush, fifoPop, fifoDrop;
    logic [OW:0]   headWord;
    logic          headEof;
    logic [TA:0]   tagCount;
    logic          tagEmpty, tagFull, tagPush, tagPop, tagHead;

    assign acc        = s_axis.tvalid & s_axis.tready;
    assign blockStart = (pixCnt_q == '0);
    assign lastBeat   = acc & (pixCnt_q == PIX_LAST);

    assign fifoCount  = wrPtr_q - rdPtr_q;
    assign fifoEmpty  = (fifoCount == '0);
    assign fifoFull   = (fifoCount == FIFO_FULL);
    assign headWord   = fifoMem[rdPtr_q[FA-1:0]];
    assign headEof    = headWord[OW];
    assign fifoPop    = ~fifoEmpty & m_axis.tready;
    assign fifoPush   = core_rsync & (~fifoFull | fifoPop);
    assign fifoDrop   = core_rsync & fifoFull & ~fifoPop;
    assign coreEofWr  = core_rsync & coreEof;

    assign tagCount   = tagWr_q - tagRd_q;
    assign tagEmpty   = (tagCount == '0);
    assign tagFull    = (tagCount == TAG_FULL);
    assign tagHead    = ~tagEmpty & tagMem_q[tagRd_q[TA-1:0]];
    assign tagPop     = fifoPop & headEof & ~tagEmpty;
    assign tagPush    = lastBeat & (~tagFull | tagPop);

    assign core_rst      = areset;
    assign core_wen      = coreWen_q;
    assign core_wdata    = coreWdata_q;

    assign s_axis.tready = rdyEn_q & (blockStart ? (rsvOk & (int'(inflight_q) < TAG_DEPTH)) : 1'b1);

    assign m_axis.tvalid = ~fifoEmpty;
    assign m_axis.tdata  = fifoEmpty ? '0 : headWord[OW-1:0];
    assign m_axis.tlast  = ~fifoEmpty & headEof & tagHead;
    assign m_axis.tkeep  = '1;

    // A new block may start only if the FIFO can hold it on top of all reserved blocks.
    always_comb begin
        rsvOk = ((FIFO_DEPTH - int'(fifoCount)) - BEATS * int'(inflight_q)) >= BEATS;
    end

    // Any lane of a core word equal to all ones marks the end of a block.
    always_comb begin
        coreEof = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (core_rdata[i*OUT_WIDTH +: OUT_WIDTH] == {OUT_WIDTH{1'b1}}) begin
                coreEof = 1'b1;
            end
        end
    end

    // Next-state for the pixel position, the blocks-in-flight count and the frame flag.
    always_comb begin
        pixCnt_d = pixCnt_q;
        if (acc) begin
            pixCnt_d = lastBeat ? '0 : pixCnt_q + PIX_STEP;
        end

        inflight_d = inflight_q;
        unique case ({acc & blockStart, coreEofWr})
            2'b10:   inflight_d = inflight_q + INF_ONE;
            2'b01:   inflight_d = inflight_q - INF_ONE;
            default: inflight_d = inflight_q;
        endcase

        fflag_d = fflag_q;
        if (lastBeat) begin
            fflag_d = 1'b0;
        end else if (acc & s_axis.tlast) begin
            fflag_d = 1'b1;
        end
    end

    // Input control registers; ready stays low for the first cycle after reset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            pixCnt_q    <= '0;
            inflight_q  <= '0;
            fflag_q     <= 1'b0;
            rdyEn_q     <= 1'b0;
            coreWen_q   <= 1'b0;
            coreWdata_q <= '0;
        end else begin
            pixCnt_q   <= pixCnt_d;
            inflight_q <= inflight_d;
            fflag_q    <= fflag_d;
            rdyEn_q    <= 1'b1;
            coreWen_q  <= acc;
            if (acc) begin
                coreWdata_q <= s_axis.tdata;
            end
        end
    end

    // Output FIFO pointers; a push while full without a pop is dropped.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (fifoPush) begin
                wrPtr_q <= wrPtr_q + PTR_ONE;
            end
            if (fifoPop) begin
                rdPtr_q <= rdPtr_q + PTR_ONE;
            end
        end
    end

    // Output FIFO storage: coded word plus its eof mark.
    always_ff @(posedge aclk) begin
        if (!areset && fifoPush) begin
            fifoMem[wrPtr_q[FA-1:0]] <= {coreEof, core_rdata};
        end
    end

    // Frame tag FIFO: one entry per block, popped when that block's eof word leaves.
    always_ff @(posedge aclk) begin
        if (areset) begin
            tagWr_q  <= '0;
            tagRd_q  <= '0;
            tagMem_q <= '0;
        end else begin
            if (tagPush) begin
                tagMem_q[tagWr_q[TA-1:0]] <= fflag_q | s_axis.tlast;
                tagWr_q                   <= tagWr_q + TAG_ONE;
            end
            if (tagPop) begin
                tagRd_q <= tagRd_q + TAG_ONE;
            end
        end
    end

`ifdef DCT_AXIS_BRIDGE_STATS_EN
    logic [31:0] blocksOut_q;
    logic [31:0] framesOut_q;
    logic        errDrop_q;

    assign blocks_out = blocksOut_q;
    assign frames_out = framesOut_q;
    assign err_drop   = errDrop_q;

    // Statistics: blocks and frames leaving the bridge, and a sticky drop flag.
    always_ff @(posedge aclk) begin
        if (areset) begin
            blocksOut_q <= '0;
            framesOut_q <= '0;
            errDrop_q   <= 1'b0;
        end else begin
            if (fifoPop && headEof) begin
                blocksOut_q <= blocksOut_q + 32'd1;
            end
            if (fifoPop && m_axis.tlast) begin
                framesOut_q <= framesOut_q + 32'd1;
            end
            if (fifoDrop) begin
                errDrop_q <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dct_axis_bridge.sv
// tb_dct_axis_bridge: drives pixel blocks into dct_axis_bridge, models the external
// core (collects a block, answers with coded words ending in an eof word) and
// predicts the output stream, ready and frame tlast from the block/frame rules.
module tb_dct_axis_bridge;

   localparam int LANES        = 2;
   localparam int IN_WIDTH     = 8;
   localparam int OUT_WIDTH    = 16;
   localparam int BLOCK_PIXELS = 64;
   localparam int FIFO_DEPTH   = 64;
   localparam int TAG_DEPTH    = 8;
   localparam int IW           = LANES * IN_WIDTH;
   localparam int OW           = LANES * OUT_WIDTH;
   localparam int BEATS        = BLOCK_PIXELS / LANES;
   localparam logic [OW/8-1:0] KEEP_ALL = '1;

   typedef struct { logic [IW-1:0] data; bit last; } beat_t;
   typedef struct { logic [OW-1:0] data; bit eof; bit tlast; } word_t;

   logic aclk;
   logic areset;
   logic core_rst;
   logic [IW-1:0] core_wdata;
   logic core_wen;
   logic [OW-1:0] core_rdata;
   logic core_rsync;
`ifdef DCT_AXIS_BRIDGE_STATS_EN
   logic [31:0] blocks_out;
   logic [31:0] frames_out;
   logic err_drop;
`endif

   dct_axis_bridge_if #(.DATA_W(IW)) s_if ();
   dct_axis_bridge_if #(.DATA_W(OW)) m_if ();

   dct_axis_bridge #(
      .LANES(LANES), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH),
      .BLOCK_PIXELS(BLOCK_PIXELS), .FIFO_DEPTH(FIFO_DEPTH), .TAG_DEPTH(TAG_DEPTH)
   ) dut (
      .aclk(aclk),
      .areset(areset),
      .s_axis(s_if),
      .m_axis(m_if),
      .core_rst(core_rst),
      .core_wdata(core_wdata),
      .core_wen(core_wen),
      .core_rdata(core_rdata),
      .core_rsync(core_rsync)
`ifdef DCT_AXIS_BRIDGE_STATS_EN
      ,
      .blocks_out(blocks_out),
      .frames_out(frames_out),
      .err_drop(err_drop)
`endif
   );

   // Free-running 10-unit clock
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Bench state and reference model
   beat_t inQ[$];
   word_t coreQ[$];
   word_t expQ[$];
   bit    frameQ[$];

   int checks = 0;
   int failures = 0;
   int tvalidPct, mreadyPct, rsyncPct, tlastPct, coreWords;
   bit srcRandom;
   int beatIdx, coreBeats, blocksStarted, eofWritten;
   bit anyLast;
   bit accPrev;
   logic [IW-1:0] dataPrev;
   int outBeats, outLasts, accCount;
   int modelBlocks, modelFrames;
   bit modelDrop;
   int waitCycles;

   // Single comparison point: counts it and reports any difference
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Core model: answer a finished block with a burst of coded words, last one eof
   task automatic genBlock();
      word_t w;
      bit flag;
      int n;
      flag = 1'b0;
      if (frameQ.size() != 0) flag = frameQ.pop_front();
      n = (coreWords != 0) ? coreWords : int'($urandom_range(BEATS / 2, BEATS));
      for (int i = 0; i < n; i++) begin
         for (int l = 0; l < LANES; l++)
            w.data[l*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'($urandom_range(0, (1 << OUT_WIDTH) - 2));
         w.eof = (i == n - 1);
         if (w.eof) w.data[OUT_WIDTH-1:0] = '1;
         w.tlast = w.eof & flag;
         coreQ.push_back(w);
      end
   endtask

   // One clock cycle: check the core port, drive inputs, check outputs, advance the model
   task automatic applyStimulus();
      bit drv, rdyExp, vldExp, pop, full, acc;
      int inflight, freeSlots;
      beat_t b;
      word_t w;
      @(negedge aclk);
      checkOutput("core_wen", 64'(core_wen), 64'(accPrev));
      if (accPrev) begin
         checkOutput("core_wdata", 64'(core_wdata), 64'(dataPrev));
         coreBeats++;
         if (coreBeats == BEATS) begin
            coreBeats = 0;
            genBlock();
         end
      end
      if (srcRandom && inQ.size() == 0) begin
         b.data = IW'($urandom);
         b.last = ($urandom_range(0, 99) < tlastPct);
         inQ.push_back(b);
      end
      drv = (inQ.size() != 0) && ($urandom_range(0, 99) < tvalidPct);
      s_if.tvalid  = drv;
      s_if.tdata   = drv ? inQ[0].data : IW'($urandom);
      s_if.tlast   = drv ? inQ[0].last : 1'b0;
      m_if.tready  = ($urandom_range(0, 99) < mreadyPct);
      core_rsync   = (coreQ.size() != 0) && ($urandom_range(0, 99) < rsyncPct);
      core_rdata   = core_rsync ? coreQ[0].data : '0;
      #1;
      inflight  = blocksStarted - eofWritten;
      freeSlots = FIFO_DEPTH - expQ.size();
      rdyExp = (beatIdx != 0) || (((freeSlots - BEATS * inflight) >= BEATS) && (inflight < TAG_DEPTH));
      vldExp = (expQ.size() != 0);
      checkOutput("s_tready", 64'(s_if.tready), 64'(rdyExp));
      checkOutput("m_tvalid", 64'(m_if.tvalid), 64'(vldExp));
      if (vldExp) begin
         checkOutput("m_tdata", 64'(m_if.tdata), 64'(expQ[0].data));
         checkOutput("m_tlast", 64'(m_if.tlast), 64'(expQ[0].tlast));
         checkOutput("m_tkeep", 64'(m_if.tkeep), 64'(KEEP_ALL));
      end else begin
         checkOutput("m_tlast_idle", 64'(m_if.tlast), 64'(0));
      end
      if (m_if.tvalid && m_if.tready) begin
         outBeats++;
         if (m_if.tlast) outLasts++;
      end
      if (s_if.tvalid && s_if.tready) accCount++;

      pop  = vldExp && m_if.tready;
      full = (expQ.size() == FIFO_DEPTH);
      if (pop) begin
         w = expQ.pop_front();
         if (w.eof) modelBlocks++;
         if (w.tlast) modelFrames++;
      end
      if (core_rsync) begin
         w = coreQ.pop_front();
         if (w.eof) eofWritten++;
         if (!full || pop) expQ.push_back(w);
         else modelDrop = 1'b1;
      end
      acc = drv && rdyExp;
      accPrev = acc;
      if (acc) begin
         b = inQ.pop_front();
         dataPrev = b.data;
         if (beatIdx == 0) blocksStarted++;
         anyLast = anyLast | b.last;
         beatIdx++;
         if (beatIdx == BEATS) begin
            frameQ.push_back(anyLast);
            anyLast = 1'b0;
            beatIdx = 0;
         end
      end
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus();
   endtask

   // Hold reset for some cycles, check the reset state and clear the model
   task automatic applyReset(input int cycles);
      areset = 1'b1;
      s_if.tvalid = 1'b0;
      s_if.tlast = 1'b0;
      core_rsync = 1'b0;
      repeat (cycles) @(posedge aclk);
      @(negedge aclk);
      #1;
      checkOutput("rst_s_tready", 64'(s_if.tready), 64'(0));
      checkOutput("rst_m_tvalid", 64'(m_if.tvalid), 64'(0));
      checkOutput("rst_m_tlast", 64'(m_if.tlast), 64'(0));
      checkOutput("rst_m_tdata", 64'(m_if.tdata), 64'(0));
      checkOutput("rst_core_wen", 64'(core_wen), 64'(0));
      checkOutput("rst_core_wdata", 64'(core_wdata), 64'(0));
      checkOutput("rst_core_rst", 64'(core_rst), 64'(1));
`ifdef DCT_AXIS_BRIDGE_STATS_EN
      checkOutput("rst_blocks_out", 64'(blocks_out), 64'(0));
      checkOutput("rst_err_drop", 64'(err_drop), 64'(0));
`endif
      areset = 1'b0;
      inQ.delete();
      coreQ.delete();
      expQ.delete();
      frameQ.delete();
      beatIdx = 0; coreBeats = 0; blocksStarted = 0; eofWritten = 0;
      anyLast = 1'b0; accPrev = 1'b0;
      modelBlocks = 0; modelFrames = 0; modelDrop = 1'b0;
   endtask

   initial begin
      areset = 1'b1;
      s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tkeep = '1;
      m_if.tready = 1'b0;
      core_rsync = 1'b0; core_rdata = '0;
      tvalidPct = 100; mreadyPct = 100; rsyncPct = 100; tlastPct = 0; coreWords = 20;
      srcRandom = 1'b0;
      applyReset(2);

      // One frame of one block: 32 beats, tlast on the last, core answers with 20 words
      for (int i = 0; i < BEATS; i++) begin
         beat_t b;
         b.data = IW'(16'h0100 + i);
         b.last = (i == BEATS - 1);
         inQ.push_back(b);
      end
      outBeats = 0; outLasts = 0;
      runCycles(150);
      checkOutput("t1_out_beats", 64'(outBeats), 64'(20));
      checkOutput("t1_out_lasts", 64'(outLasts), 64'(1));

      // Output stalled: two blocks admitted, the third start is held back
      applyReset(1);
      srcRandom = 1'b1; tlastPct = 0; tvalidPct = 100; mreadyPct = 0; rsyncPct = 100; coreWords = 32;
      accCount = 0;
      runCycles(300);
      checkOutput("t2_accepted", 64'(accCount), 64'(2 * BEATS));
      checkOutput("t2_s_tready", 64'(s_if.tready), 64'(0));
      checkOutput("t2_m_tvalid", 64'(m_if.tvalid), 64'(1));
      mreadyPct = 100;
      runCycles(150);

      // Randomised traffic with random frame ends, valid, ready and core pacing
      tvalidPct = 70; mreadyPct = 60; rsyncPct = 50; tlastPct = 5; coreWords = 0;
      runCycles(3000);

      // Reset with words queued and the next block half received
      applyReset(1);
      srcRandom = 1'b1; tlastPct = 0; tvalidPct = 100; mreadyPct = 0; rsyncPct = 100; coreWords = 16;
      waitCycles = 0;
      while (!(expQ.size() >= 10 && beatIdx != 0) && waitCycles < 500) begin
         applyStimulus();
         waitCycles++;
      end
      checkOutput("t5_fill_in_time", 64'(waitCycles < 500), 64'(1));
      applyReset(2);

      // Frame ends on beat 5: block still takes all 32 beats, tlast on its eof word
      srcRandom = 1'b0; tvalidPct = 100; mreadyPct = 100; rsyncPct = 100; coreWords = 12;
      for (int i = 0; i < BEATS; i++) begin
         beat_t b;
         b.data = IW'($urandom);
         b.last = (i == 4);
         inQ.push_back(b);
      end
      outBeats = 0; outLasts = 0; accCount = 0;
      runCycles(120);
      checkOutput("t4_accepted", 64'(accCount), 64'(BEATS));
      checkOutput("t4_out_beats", 64'(outBeats), 64'(12));
      checkOutput("t4_out_lasts", 64'(outLasts), 64'(1));

      // Core over-produces 70 words without eof into a stalled output
      mreadyPct = 0; rsyncPct = 100;
      for (int i = 0; i < 70; i++) begin
         word_t w;
         w.data = OW'($urandom_range(0, 16'hFFFE));
         w.eof = 1'b0;
         w.tlast = 1'b0;
         coreQ.push_back(w);
      end
      runCycles(80);
      checkOutput("t6_m_tvalid", 64'(m_if.tvalid), 64'(1));
`ifdef DCT_AXIS_BRIDGE_STATS_EN
      checkOutput("t6_err_drop", 64'(err_drop), 64'(modelDrop));
      checkOutput("t6_blocks_out", 64'(blocks_out), 64'(modelBlocks));
      checkOutput("t6_frames_out", 64'(frames_out), 64'(modelFrames));
`endif
      mreadyPct = 100; outBeats = 0;
      runCycles(80);
      checkOutput("t6_drained", 64'(outBeats), 64'(FIFO_DEPTH));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
